// File: rtl/rx_ctrl.sv
// Receive-side capture/streamer: a trig captures N consecutive ADC words into an elastic
// first-word-fall-through FIFO and streams them out as one AXI-stream packet.
module rx_ctrl #(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             trig_i,
  input  logic [CNT_W-1:0] rxsmps_i,
  input  logic [31:0]      adc_data_i,
  output logic [31:0]      m_tdata_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic             busy_o,
  output logic             ovf_o
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] OccOne = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StCapt, StDrain} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] n_q, cnt_q;
  logic             ovf_q, last_lost_q;
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic [32:0]      mem_q [Depth];

  logic [FIFO_AW:0] occ;
  logic             empty, full, pop, push, drop, is_last;
  logic [32:0]      head;

  assign occ     = wr_ptr_q - rd_ptr_q;
  assign empty   = (occ == '0);
  assign full    = occ[FIFO_AW];
  assign pop     = !empty && m_tready_i;
  assign is_last = (cnt_q == n_q - 1'b1);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
  assign push    = (state_q == StCapt) && (!full || pop);
  assign drop    = (state_q == StCapt) && full && !pop;
  assign head    = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      n_q         <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      last_lost_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          if (trig_i && (rxsmps_i != '0)) begin
            n_q         <= rxsmps_i;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            last_lost_q <= 1'b0;
            state_q     <= StCapt;
          end
        end
        StCapt: begin
          cnt_q <= cnt_q + 1'b1;
          if (drop) begin
            ovf_q <= 1'b1;
            if (is_last) last_lost_q <= 1'b1;
          end
          if (is_last) state_q <= StDrain;
        end
        StDrain: begin
          if (empty || (pop && (occ == OccOne))) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {is_last, adc_data_i};
  end

  // With the final word dropped, the tail entry left in the FIFO closes the packet.
  assign m_tvalid_o = !empty;
  assign m_tdata_o  = empty ? 32'd0 : head[31:0];
  assign m_tlast_o  = !empty && (head[32] || (last_lost_q && (occ == OccOne)));
  assign busy_o     = (state_q != StIdle);
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_rx_ctrl.sv
// Bench for rx_ctrl: queue-based reference model fills a scoreboard of expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_rx_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] rxsmps = '0;
  logic [31:0] adc = '0;
  logic        tready = 1'b0;
  logic [31:0] tdata;
  logic        tvalid, tlast, busy, ovf;

  rx_ctrl #(.FIFO_AW(4), .CNT_W(16)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .trig_i     (trig),
    .rxsmps_i   (rxsmps),
    .adc_data_i (adc),
    .m_tdata_o  (tdata),
    .m_tvalid_o (tvalid),
    .m_tready_i (tready),
    .m_tlast_o  (tlast),
    .busy_o     (busy),
    .ovf_o      (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int beats = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a 16-entry queue filled one word per cycle while capturing.
  logic [32:0] exp_q[$];
  int occ = 0;
  int m_state = 0;   // 0 idle, 1 capturing, 2 draining
  int m_n = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q.delete();
      occ = 0;
      m_state = 0;
      m_ovf = 1'b0;
    end else begin
      int pop;
      int push;
      bit lst;
      pop = (occ > 0 && tready) ? 1 : 0;
      push = 0;
      case (m_state)
        0: begin
          if (trig && rxsmps != 0) begin
            m_n = int'(rxsmps);
            m_cnt = 0;
            m_ovf = 1'b0;
            m_state = 1;
          end
        end
        1: begin
          lst = (m_cnt == m_n - 1);
          if (occ - pop < 16) begin
            exp_q.push_back({lst, adc});
            push = 1;
          end else begin
            m_ovf = 1'b1;
            if (lst && exp_q.size() > 0) exp_q[exp_q.size()-1][32] = 1'b1;
          end
          m_cnt++;
          if (m_cnt == m_n) m_state = 2;
        end
        default: begin
          if (occ - pop == 0) m_state = 0;
        end
      endcase
      occ = occ - pop + push;
    end
  end

  // Monitor / scoreboard.
  bit          stall_q = 1'b0;
  logic [32:0] stall_v = '0;

  always @(negedge clk) begin
    if (rstn) begin
      chk("tvalid", tvalid, occ > 0);
      chk("busy", busy, m_state != 0);
      chk("ovf", ovf, m_ovf);
      if (stall_q && tvalid) chk("stall_hold", {tlast, tdata}, stall_v);
      if (tvalid && tready) begin
        beats++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got %h expected none", {tlast, tdata});
        end else begin
          chk("beat", {tlast, tdata}, exp_q.pop_front());
        end
      end
      stall_q = tvalid && !tready;
      stall_v = {tlast, tdata};
    end else begin
      stall_q = 1'b0;
    end
  end

  // mode: 0 ready high, 1 toggling, 2 low until cycle 'hold', 3 random
  task automatic run(input int n, input int mode, input int hold, input int trig2,
                     input int rst_at, input int exp_beats, input string name);
    int c;
    c = 0;
    beats = 0;
    forever begin
      @(posedge clk);
      #1;
      if (c >= 3 && m_state == 0 && occ == 0) break;
      if (c > 2000) begin
        total++;
        bad++;
        $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, c);
        break;
      end
      trig = (c == 0) || (c == trig2);
      rxsmps = (c == 0) ? 16'(n) : 16'($urandom_range(1, 30));
      adc = $urandom;
      case (mode)
        0: tready = 1'b1;
        1: tready = c[0];
        2: tready = (c > hold);
        default: tready = 1'($urandom_range(0, 1));
      endcase
      if (c == rst_at) begin
        rstn = 1'b0;
        #1;
        chk({name, "_rst_tvalid"}, tvalid, 1'b0);
        chk({name, "_rst_tdata"}, tdata, 32'd0);
        chk({name, "_rst_tlast"}, tlast, 1'b0);
        chk({name, "_rst_busy"}, busy, 1'b0);
        chk({name, "_rst_ovf"}, ovf, 1'b0);
        trig = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        return;
      end
      c++;
    end
    trig = 1'b0;
    tready = 1'b0;
    @(negedge clk);
    chk({name, "_sb_empty"}, 33'(exp_q.size()), 33'd0);
    if (exp_beats >= 0) chk({name, "_beats"}, 33'(beats), 33'(exp_beats));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tvalid", tvalid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ovf", ovf, 1'b0);
    chk("reset_tlast", tlast, 1'b0);
    rstn = 1'b1;

    run(4, 0, 0, -1, -1, 4, "n4_ready");
    chk("n4_ovf", ovf, 1'b0);
    run(20, 2, 25, -1, -1, 16, "n20_fill");
    chk("n20_ovf", ovf, 1'b1);
    run(8, 1, 0, -1, -1, 8, "n8_toggle");
    run(6, 0, 0, 2, -1, 6, "n6_retrig");
    run(0, 0, 0, -1, -1, 0, "n0_ignored");
    chk("n0_ovf_kept", ovf, 1'b0);
    run(10, 0, 0, -1, 4, -1, "n10_reset");
    run(10, 0, 0, -1, -1, 10, "n10_fresh");
    chk("n10_ovf", ovf, 1'b0);
    run(20, 2, 16, -1, -1, 20, "full_pushpop");
    chk("full_pushpop_ovf", ovf, 1'b0);
    for (int i = 0; i < 8; i++) run($urandom_range(1, 40), 3, 0, -1, -1, -1, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
